// File: rtl/ws2812_in.sv
// WS2812 one-wire receiver: measures high-pulse widths, recovers bits MSB first
// and emits 16-bit words with a frame-relative index on a strobed word bus.
module ws2812_in #(
    parameter int unsigned ADDRESS_BUS_WIDTH = 13,
    parameter int unsigned WORD_COUNT        = 96,
    parameter int unsigned THRESHOLD_CYCLES  = 12,
    parameter int unsigned GLITCH_CYCLES     = 3,
    parameter int unsigned RESET_CYCLES      = 1200,
    parameter int unsigned STUCK_CYCLES      = 2400
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         data_in,
    output logic [15:0]                  data,
    output logic [ADDRESS_BUS_WIDTH:0]   address,
    output logic                         write_strobe,
    output logic                         frame_done,
    output logic                         overflow
);

    localparam int unsigned CW = $clog2(STUCK_CYCLES + 1);
    localparam int unsigned IW = $clog2(WORD_COUNT + 1);
    localparam int unsigned AW = ADDRESS_BUS_WIDTH + 1;

    typedef enum logic [1:0] {WAIT_LATCH, IDLE, LOW, HIGH} state_t;

    state_t          state, state_n;
    logic            sync1, sync2, line_d, rise, fall;
    logic [CW-1:0]   cnt, cnt_n, cnt_inc;
    logic [3:0]      bits, bits_n;
    logic [15:0]     shift, shift_n, word, word_n;
    logic [IW-1:0]   idx, idx_n, waddr, waddr_n;
    logic            ovf_n, emit, emit_n, done, done_n, bit_c;

    // Synchroniser followed by a registered edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            line_d <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync1  <= data_in;
            sync2  <= sync1;
            line_d <= sync2;
            rise   <= sync2 & ~line_d;
            fall   <= ~sync2 & line_d;
        end
    end

    assign cnt_inc = (cnt == CW'(STUCK_CYCLES)) ? cnt : cnt + CW'(1);
    assign bit_c   = (cnt >= CW'(THRESHOLD_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= WAIT_LATCH;
            cnt      <= '0;
            bits     <= '0;
            shift    <= '0;
            idx      <= '0;
            overflow <= 1'b0;
            emit     <= 1'b0;
            done     <= 1'b0;
            word     <= '0;
            waddr    <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bits     <= bits_n;
            shift    <= shift_n;
            idx      <= idx_n;
            overflow <= ovf_n;
            emit     <= emit_n;
            done     <= done_n;
            word     <= word_n;
            waddr    <= waddr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bits_n  = bits;
        shift_n = shift;
        idx_n   = idx;
        ovf_n   = overflow;
        emit_n  = 1'b0;
        done_n  = 1'b0;
        word_n  = word;
        waddr_n = waddr;
        case (state)
            WAIT_LATCH: begin
                if (line_d) begin
                    cnt_n = '0;
                end else if (cnt_inc >= CW'(RESET_CYCLES)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_n = HIGH;
                    cnt_n   = CW'(1);
                end
            end
            LOW: begin
                if (rise) begin
                    state_n = HIGH;
                    cnt_n   = CW'(1);
                end else if (cnt_inc == CW'(RESET_CYCLES)) begin
                    // Frame latch: drop any partial word and restart indexing.
                    state_n = IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    bits_n  = '0;
                    shift_n = '0;
                    idx_n   = '0;
                    ovf_n   = 1'b0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_n = LOW;
                    cnt_n   = CW'(1);
                    if (cnt >= CW'(GLITCH_CYCLES)) begin
                        shift_n = {shift[14:0], bit_c};
                        if (bits == 4'd15) begin
                            bits_n = '0;
                            if (idx < IW'(WORD_COUNT)) begin
                                emit_n  = 1'b1;
                                word_n  = {shift[14:0], bit_c};
                                waddr_n = idx;
                                idx_n   = idx + IW'(1);
                            end else begin
                                ovf_n = 1'b1;
                            end
                        end else begin
                            bits_n = bits + 4'd1;
                        end
                    end
                end else if (cnt_inc == CW'(STUCK_CYCLES)) begin
                    // Line fault: abandon the frame silently and wait for a clean latch.
                    state_n = WAIT_LATCH;
                    cnt_n   = '0;
                    bits_n  = '0;
                    shift_n = '0;
                    idx_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: state_n = WAIT_LATCH;
        endcase
    end

    // Output register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data         <= '0;
            address      <= '0;
            write_strobe <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            write_strobe <= emit;
            frame_done   <= done;
            if (emit) begin
                data    <= word;
                address <= AW'(waddr);
            end
        end
    end

endmodule

// File: tb/tb_ws2812_in.sv
// Bench for ws2812_in: random pulse timing against a frame-level reference model,
// with a second instance at WORD_COUNT=4 for the overflow path.
module tb_ws2812_in;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_in;
    logic [15:0] data_a, data_b;
    logic [13:0] addr_a, addr_b;
    logic        ws_a, ws_b, fd_a, fd_b, ov_a, ov_b;

    always #5 clk = ~clk;

    ws2812_in u_a (
        .clk(clk), .rst(rst), .data_in(data_in), .data(data_a), .address(addr_a),
        .write_strobe(ws_a), .frame_done(fd_a), .overflow(ov_a)
    );

    ws2812_in #(.WORD_COUNT(4)) u_b (
        .clk(clk), .rst(rst), .data_in(data_in), .data(data_b), .address(addr_b),
        .write_strobe(ws_b), .frame_done(fd_b), .overflow(ov_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor
    logic [15:0] got_d   [512];
    logic [13:0] got_adr [512];
    int          got_c   [512];
    int          got_n = 0;
    int          fd_got_a = 0, fd_got_b = 0, ws_got_b = 0;
    bit          clash = 1'b0;

    always @(negedge clk) begin
        if (ws_a && got_n < 512) begin
            got_d[got_n]   = data_a;
            got_adr[got_n] = addr_a;
            got_c[got_n]   = cyc;
            got_n          = got_n + 1;
        end
        if (fd_a) fd_got_a = fd_got_a + 1;
        if (fd_b) fd_got_b = fd_got_b + 1;
        if (ws_b) ws_got_b = ws_got_b + 1;
        if ((ws_a && fd_a) || (ws_b && fd_b)) clash = 1'b1;
    end

    // Reference model: tracks the frame in terms of pulses, words and latches.
    typedef struct {
        logic [15:0] d;
        logic [13:0] a;
        int          c;
    } ev_t;

    ev_t         exp_q[$];
    int          rd = 0;
    bit          armed = 1'b0, pending = 1'b0, ovb = 1'b0;
    int          nb = 0, ia = 0, ib = 0, fd_exp = 0, ws_exp_b = 0;
    logic [15:0] acc = '0;

    task automatic pulse(input int hi, input int lo);
        int cfall;
        data_in = 1'b1;
        repeat (hi) @(negedge clk);
        data_in = 1'b0;
        cfall   = cyc;
        if (hi >= 2400) begin
            armed = 1'b0; pending = 1'b0; nb = 0; ia = 0; ib = 0;
        end else if (armed) begin
            pending = 1'b1;
            if (hi >= 3) begin
                acc = {acc[14:0], (hi >= 12)};
                nb  = nb + 1;
                if (nb == 16) begin
                    nb = 0;
                    if (ia < 96) begin
                        exp_q.push_back('{d: acc, a: 14'(ia), c: cfall + 5});
                        ia = ia + 1;
                    end
                    if (ib < 4) begin
                        ws_exp_b = ws_exp_b + 1;
                        ib = ib + 1;
                    end else begin
                        ovb = 1'b1;
                    end
                end
            end
        end
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w, input bit rnd);
        int hi, lo;
        for (int i = 15; i >= 0; i--) begin
            if (rnd) begin
                hi = w[i] ? int'($urandom_range(22, 12)) : int'($urandom_range(11, 3));
                lo = int'($urandom_range(30, 8));
            end else begin
                hi = w[i] ? 17 : 8;
                lo = w[i] ? 13 : 22;
            end
            pulse(hi, lo);
        end
    endtask

    task automatic latch(input int n);
        data_in = 1'b0;
        repeat (n) @(negedge clk);
        if (n >= 1200) begin
            if (armed) begin
                if (pending) begin
                    fd_exp = fd_exp + 1;
                    ovb = 1'b0; ia = 0; ib = 0; nb = 0;
                end
                pending = 1'b0;
            end else begin
                armed = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        data_in = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({data_a, addr_a} !== 30'h0) begin
            bad++; $display("FAIL reset_bus got data=%h addr=%0d want 0/0", data_a, addr_a);
        end
        total++;
        if ({ws_a, fd_a, ov_a, ws_b, fd_b, ov_b} !== 6'b0) begin
            bad++; $display("FAIL reset_flags got %b want 000000", {ws_a, fd_a, ov_a, ws_b, fd_b, ov_b});
        end
        rst = 1'b0;
        latch(1300);
        total++;
        if (fd_got_a !== 0) begin
            bad++; $display("FAIL reset_no_fd got %0d frame_done want 0", fd_got_a);
        end
    endtask

    task automatic test_words(input string name);
        ev_t e;
        total++;
        if (got_n - rd != exp_q.size()) begin
            bad++; $display("FAIL %s strobe_count got %0d want %0d", name, got_n - rd, exp_q.size());
        end
        while (exp_q.size() > 0 && rd < got_n) begin
            e = exp_q.pop_front();
            total++;
            if (got_d[rd] !== e.d || got_adr[rd] !== e.a || got_c[rd] !== e.c) begin
                bad++;
                $display("FAIL %s word got %h@%0d cyc %0d want %h@%0d cyc %0d",
                         name, got_d[rd], got_adr[rd], got_c[rd], e.d, e.a, e.c);
            end
            rd++;
        end
        exp_q.delete();
        rd = got_n;
        total++;
        if (fd_got_a !== fd_exp || fd_got_b !== fd_exp) begin
            bad++; $display("FAIL %s frame_done got %0d/%0d want %0d", name, fd_got_a, fd_got_b, fd_exp);
        end
    endtask

    task automatic test_basic;
        send_word(16'hA5C3, 1'b0);
        latch(1300);
        test_words("basic");
    endtask

    task automatic test_multi;
        send_word(16'h0001, 1'b1);
        send_word(16'hFFFF, 1'b1);
        send_word(16'h8000, 1'b1);
        latch(1300);
        send_word(16'h1234, 1'b1);
        latch(1300);
        test_words("multi");
    endtask

    task automatic test_random;
        for (int k = 0; k < 6; k++) send_word(16'($urandom), 1'b1);
        latch(1300);
        test_words("random");
    endtask

    task automatic test_overflow;
        for (int k = 0; k < 5; k++) send_word(16'($urandom), 1'b1);
        repeat (10) @(negedge clk);
        total++;
        if (ws_got_b !== ws_exp_b || ov_b !== ovb) begin
            bad++; $display("FAIL overflow_set got strobes=%0d ovf=%b want %0d/%b", ws_got_b, ov_b, ws_exp_b, ovb);
        end
        latch(1300);
        total++;
        if (ov_b !== ovb || ov_a !== 1'b0) begin
            bad++; $display("FAIL overflow_clear got %b/%b want %b/0", ov_b, ov_a, ovb);
        end
        test_words("overflow");
    endtask

    task automatic test_partial;
        for (int k = 0; k < 10; k++) pulse(int'($urandom_range(22, 3)), int'($urandom_range(30, 8)));
        latch(1300);
        send_word(16'hBEEF, 1'b1);
        latch(1300);
        test_words("partial");
    endtask

    task automatic test_glitch_boundary;
        int his[16] = '{12, 11, 3, 12, 3, 11, 12, 12, 3, 3, 11, 12, 12, 3, 11, 12};
        logic [15:0] w = 16'h5A5A;
        for (int i = 15; i >= 0; i--) begin
            pulse(2, int'($urandom_range(20, 5)));
            pulse(w[i] ? 17 : 8, w[i] ? 13 : 22);
        end
        for (int i = 0; i < 16; i++) pulse(his[i], int'($urandom_range(30, 8)));
        latch(1300);
        test_words("glitch_boundary");
    endtask

    task automatic test_stuck;
        for (int k = 0; k < 5; k++) pulse(17, 13);
        pulse(2500, 20);
        send_word(16'h1111, 1'b1);
        test_words("stuck_abort");
        latch(1300);
        send_word(16'($urandom), 1'b1);
        latch(1300);
        test_words("stuck_recover");
    endtask

    task automatic test_async_reset;
        for (int k = 0; k < 5; k++) send_word(16'($urandom | 32'h1), 1'b1);
        for (int k = 0; k < 8; k++) pulse(17, 13);
        test_words("pre_reset");
        total++;
        if (ov_b !== 1'b1) begin
            bad++; $display("FAIL pre_reset_ovf got %b want 1", ov_b);
        end
        data_in = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({data_a, addr_a, ws_a, fd_a, ov_a, ov_b} !== 34'h0) begin
            bad++; $display("FAIL async_reset got data=%h addr=%0d ovf=%b want 0/0/0", data_a, addr_a, ov_b);
        end
        armed = 1'b0; pending = 1'b0; nb = 0; ia = 0; ib = 0; ovb = 1'b0;
        @(negedge clk);
        data_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send_word(16'h3C3C, 1'b1);
        total++;
        if (data_a !== 16'h0) begin
            bad++; $display("FAIL post_reset_hold got data=%h want 0000", data_a);
        end
        test_words("post_reset_nolatch");
        latch(1300);
        send_word(16'($urandom), 1'b1);
        latch(1300);
        test_words("post_reset_latch");
        total++;
        if (clash !== 1'b0) begin
            bad++; $display("FAIL strobe_vs_frame_done got coincidence=%b want 0", clash);
        end
    endtask

    initial begin
        rst = 1'b1;
        data_in = 1'b0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_multi;
        test_random;
        test_overflow;
        test_partial;
        test_glitch_boundary;
        test_stuck;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
